// File: rtl/data_mem_dumper_pkg.sv
// Shared debug-unit definitions: dump FSM state encoding and bytes-per-word constant.
package data_mem_dumper_pkg;

    localparam int STATE_W = 3;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LATCH = 3'd1;
    localparam logic [2:0] S_SEND  = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int         BYTES_PER_WORD = 4;
    localparam logic [1:0] LAST_BYTE_IDX  = 2'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/data_mem_dumper.sv
// Streams DUMP_WORDS words of data memory to an external UART, LSB first,
// once the pipeline is halted and a dump is requested.
//
// Handshake: o_tx_start is a one-cycle strobe with o_tx_data valid in that
// cycle; the transmitter answers with a one-cycle i_tx_done when the byte is
// gone. Only i_tx_done seen in WAIT advances the stream; all other pulses are
// dropped.
module data_mem_dumper
    import data_mem_dumper_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 12,
    parameter int DUMP_WORDS     = 1024
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_halt,
    input  logic                      i_start,
    output logic [MEM_ADDR_WIDTH-1:0] o_mem_addr,
    input  logic [31:0]               i_mem_data,
    output logic [7:0]                o_tx_data,
    output logic                      o_tx_start,
    input  logic                      i_tx_done,
    output logic                      o_busy,
    output logic                      o_done,
    output logic [STATE_W-1:0]        o_dbg_state
);

    localparam int              WIDX_W    = (DUMP_WORDS > 1) ? $clog2(DUMP_WORDS) : 1;
    localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(DUMP_WORDS - 1);

    logic [STATE_W-1:0] r_state;
    logic [WIDX_W-1:0]  r_word_idx;
    logic [1:0]         r_byte_idx;
    logic [31:0]        r_shift;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_word_idx <= '0;
            r_byte_idx <= '0;
            r_shift    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start && i_halt) begin
                        r_word_idx <= '0;
                        r_state    <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    r_shift    <= i_mem_data;
                    r_byte_idx <= '0;
                    r_state    <= S_SEND;
                end
                S_SEND: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_tx_done) begin
                        if (r_byte_idx != LAST_BYTE_IDX) begin
                            r_shift    <= r_shift >> 8;
                            r_byte_idx <= r_byte_idx + 2'd1;
                            r_state    <= S_SEND;
                        end else if (r_word_idx == LAST_WORD) begin
                            r_state <= S_DONE;
                        end else begin
                            r_word_idx <= r_word_idx + WIDX_W'(1);
                            r_state    <= S_LATCH;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs are forced low while reset is held so nothing leaks out in the reset cycle itself.
    assign o_tx_start  = !i_reset && (r_state == S_SEND);
    assign o_busy      = !i_reset && (r_state != S_IDLE);
    assign o_done      = !i_reset && (r_state == S_DONE);
    assign o_tx_data   = i_reset ? 8'h00 : r_shift[7:0];
    assign o_mem_addr  = i_reset ? '0 : MEM_ADDR_WIDTH'({r_word_idx, 2'b00});
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_data_mem_dumper.sv
// Self-checking bench: a two-word dumper for the directed corner cases and a
// default-sized dumper for the full 4096-byte run.
module tb_data_mem_dumper;
    import data_mem_dumper_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        s_reset, s_halt, s_start, s_tx_done;
    logic [11:0] s_mem_addr;
    logic [31:0] s_mem_data;
    logic [7:0]  s_tx_data;
    logic        s_tx_start, s_busy, s_done;
    logic [2:0]  s_state;

    logic        b_reset, b_halt, b_start, b_tx_done;
    logic [11:0] b_mem_addr;
    logic [31:0] b_mem_data;
    logic [7:0]  b_tx_data;
    logic        b_tx_start, b_busy, b_done;
    logic [2:0]  b_state;

    assign s_mem_data = (s_mem_addr[11:2] == 10'd0) ? 32'h44332211 :
                        (s_mem_addr[11:2] == 10'd1) ? 32'h88776655 : 32'hDEADBEEF;
    assign b_mem_data = {22'd0, b_mem_addr[11:2]};

    data_mem_dumper #(.MEM_ADDR_WIDTH(12), .DUMP_WORDS(2)) dut_small (
        .i_clk(clk), .i_reset(s_reset), .i_halt(s_halt), .i_start(s_start),
        .o_mem_addr(s_mem_addr), .i_mem_data(s_mem_data),
        .o_tx_data(s_tx_data), .o_tx_start(s_tx_start), .i_tx_done(s_tx_done),
        .o_busy(s_busy), .o_done(s_done), .o_dbg_state(s_state)
    );

    data_mem_dumper dut_big (
        .i_clk(clk), .i_reset(b_reset), .i_halt(b_halt), .i_start(b_start),
        .o_mem_addr(b_mem_addr), .i_mem_data(b_mem_data),
        .o_tx_data(b_tx_data), .o_tx_start(b_tx_start), .i_tx_done(b_tx_done),
        .o_busy(b_busy), .o_done(b_done), .o_dbg_state(b_state)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         dly;
        logic [7:0] exp_byte;
        logic [11:0] exp_addr;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
    endtask

    // Waits for a strobe, captures it, then answers i_tx_done dly cycles later.
    task automatic serve_byte(input int dly, input bit glitch, output logic [7:0] b,
                              output logic [11:0] a, output bit ok, output bit stable);
        int n = 0;
        stable = 1'b1;
        while (!s_tx_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = s_tx_start;
        b  = s_tx_data;
        a  = s_mem_addr;
        if (glitch) begin
            s_tx_done = 1'b1;
            s_start   = 1'b1;
        end
        @(negedge clk);
        s_tx_done = 1'b0;
        s_start   = 1'b0;
        for (int i = 1; i < dly; i++) begin
            if (s_tx_start || s_tx_data !== b || s_state !== S_WAIT) stable = 1'b0;
            @(negedge clk);
        end
        if (s_tx_start || s_tx_data !== b || s_state !== S_WAIT) stable = 1'b0;
        s_tx_done = 1'b1;
        @(negedge clk);
        s_tx_done = 1'b0;
    endtask

    task automatic run_bytes(input string tag, input bit glitch, input int first, input int last);
        logic [7:0]  b;
        logic [11:0] a;
        bit          ok, stable;
        for (int i = first; i <= last; i++) begin
            serve_byte(vecs[i].dly, glitch, b, a, ok, stable);
            check($sformatf("%s_strobe%0d", tag, i), 32'(ok), 32'd1);
            check($sformatf("%s_byte%0d", tag, i), 32'(b), 32'(vecs[i].exp_byte));
            check($sformatf("%s_addr%0d", tag, i), 32'(a), 32'(vecs[i].exp_addr));
            check($sformatf("%s_hold%0d", tag, i), 32'(stable), 32'd1);
        end
    endtask

    // After the last byte's i_tx_done: one DONE cycle, then idle with no further strobes.
    task automatic finish_check(input string tag);
        bit stray = 1'b0;
        check({tag, "_done_pulse"}, 32'(s_done), 32'd1);
        @(negedge clk);
        check({tag, "_done_low"}, 32'(s_done), 32'd0);
        check({tag, "_idle_busy"}, 32'(s_busy), 32'd0);
        for (int i = 0; i < 10; i++) begin
            if (s_tx_start || s_busy) stray = 1'b1;
            @(negedge clk);
        end
        check({tag, "_no_extra_bytes"}, 32'(stray), 32'd0);
    endtask

    initial begin
        bit          flag;
        int          cnt, err, done_cnt, cyc, w;
        bit          pend;
        logic [7:0]  exp_b;
        logic [11:0] last_addr;

        for (int i = 0; i < 8; i++) begin
            vecs[i].dly      = 3;
            vecs[i].exp_byte = 8'(8'h11 * (i + 1));
            vecs[i].exp_addr = (i < 4) ? 12'h000 : 12'h004;
        end

        s_reset = 1'b1; s_halt = 1'b0; s_start = 1'b0; s_tx_done = 1'b0;
        b_reset = 1'b1; b_halt = 1'b0; b_start = 1'b0; b_tx_done = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx_start", 32'(s_tx_start), 32'd0);
        check("rst_tx_data",  32'(s_tx_data),  32'd0);
        check("rst_busy",     32'(s_busy),     32'd0);
        check("rst_done",     32'(s_done),     32'd0);
        check("rst_mem_addr", 32'(s_mem_addr), 32'd0);
        s_reset = 1'b0;
        b_reset = 1'b0;
        @(negedge clk);
        check("post_rst_state", 32'(s_state), 32'(S_IDLE));
        check("post_rst_busy",  32'(s_busy),  32'd0);

        // Start without halt is ignored.
        s_halt = 1'b0;
        do_start();
        flag = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (s_busy || s_tx_start) flag = 1'b1;
            @(negedge clk);
        end
        check("nohalt_ignored", 32'(flag), 32'd0);

        // Basic two-word dump with first-strobe latency.
        s_halt = 1'b1;
        do_start();
        check("lat_cycle1_latch", 32'(s_state), 32'(S_LATCH));
        check("lat_cycle1_nostrobe", 32'(s_tx_start), 32'd0);
        check("lat_cycle1_busy", 32'(s_busy), 32'd1);
        @(negedge clk);
        check("lat_cycle2_strobe", 32'(s_tx_start), 32'd1);
        run_bytes("basic", 1'b0, 0, 7);
        finish_check("basic");

        // Withheld i_tx_done, with halt dropped mid-dump.
        do_start();
        s_halt = 1'b0;
        @(negedge clk);
        check("stall_first_strobe", 32'(s_tx_start), 32'd1);
        check("stall_first_byte", 32'(s_tx_data), 32'h11);
        @(negedge clk);
        flag = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (s_state !== S_WAIT || s_tx_data !== 8'h11 || s_tx_start) flag = 1'b1;
            @(negedge clk);
        end
        check("stall_held_in_wait", 32'(flag), 32'd0);
        s_tx_done = 1'b1;
        @(negedge clk);
        s_tx_done = 1'b0;
        run_bytes("stall", 1'b0, 1, 7);
        finish_check("stall");
        s_halt = 1'b1;

        // Reset during the dump, right as the fourth byte is being strobed.
        do_start();
        run_bytes("prerst", 1'b0, 0, 2);
        s_reset = 1'b1;
        #1;
        check("midrst_tx_start", 32'(s_tx_start), 32'd0);
        check("midrst_busy",     32'(s_busy),     32'd0);
        @(negedge clk);
        s_reset = 1'b0;
        check("afterrst_state",    32'(s_state),    32'(S_IDLE));
        check("afterrst_tx_start", 32'(s_tx_start), 32'd0);
        check("afterrst_tx_data",  32'(s_tx_data),  32'd0);
        check("afterrst_busy",     32'(s_busy),     32'd0);
        check("afterrst_done",     32'(s_done),     32'd0);
        check("afterrst_mem_addr", 32'(s_mem_addr), 32'd0);
        do_start();
        run_bytes("restart", 1'b0, 0, 7);
        finish_check("restart");

        // Stray i_start and i_tx_done pulses during SEND.
        do_start();
        run_bytes("glitch", 1'b1, 0, 7);
        finish_check("glitch");

        // Full default-size dump, memory word n holds n.
        b_halt = 1'b1;
        @(negedge clk);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        cnt = 0; err = 0; done_cnt = 0; cyc = 0; pend = 1'b0; last_addr = '0;
        while (done_cnt == 0 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            b_tx_done = pend;
            pend = 1'b0;
            if (b_tx_start) begin
                w = cnt / 4;
                exp_b = 8'((w >> (8 * (cnt % 4))) & 255);
                if (b_tx_data !== exp_b) err++;
                last_addr = b_mem_addr;
                cnt++;
                pend = 1'b1;
            end
            if (b_done) done_cnt++;
        end
        b_tx_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (b_tx_start) cnt++;
            if (b_done) done_cnt++;
        end
        check("full_byte_count", 32'(cnt), 32'd4096);
        check("full_byte_errors", 32'(err), 32'd0);
        check("full_last_addr", 32'(last_addr), 32'hFFC);
        check("full_done_pulses", 32'(done_cnt), 32'd1);
        check("full_idle_busy", 32'(b_busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
